mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sits directly downstream of the pipelined datapath's two memory ports: instruction fetch (port 1) and data load/store (port 2). Serializes both onto one single-ported memory with a req/ack handshake. Returns per-port ready pulses so the datapath can stall. Holds a one-entry fetch buffer so that repeated fetches of the same address complete without a memory access.

## Interface
Parameters:
- WIDTH, 16, data and address width (matches `WORD_SIZE`)
- HIT_EN, 1, enables the one-entry fetch buffer; 0 forces every fetch to memory

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- readM1  input  1  fetch request from datapath
- address1  input  WIDTH  fetch address
- data1  output  WIDTH  fetched instruction, registered
- ready1  output  1  one-cycle pulse: data1 valid, fetch complete
- readM2  input  1  data read request
- writeM2  input  1  data write request (readM2 and writeM2 are never both high)
- address2  input  WIDTH  data address
- data2  inout  WIDTH  write data in; read data out
- ready2  output  1  one-cycle pulse: port-2 access complete
- mem_req  output  1  memory request, held until acked
- mem_we  output  1  1 = write
- mem_addr  output  WIDTH  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_rdata  input  WIDTH  memory read data, valid with mem_ack
- mem_ack  input  1  memory completion, sampled at clk edge while mem_req=1

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- **IDLE** evaluates requests at each edge. Port 2 has fixed priority over port 1.
  - readM2|writeM2: latch address2 into mem_addr, writeM2 into mem_we, and data2 into mem_wdata. Set mem_req=1. Go to BUSY_D.
  - Else readM1 with HIT_EN, buffer valid, and address1==tag: load data1 from buffer. Go to DONE (port 1).
  - Else readM1: set mem_addr=address1, mem_we=0, mem_req=1. Go to BUSY_I.
  - Else stay in IDLE.
- **BUSY_I / BUSY_D**: mem_req, mem_addr, mem_we and mem_wdata stay stable. Requester inputs are ignored.
  - On an edge with mem_ack=1, drop mem_req and go to DONE.
  - BUSY_I: capture mem_rdata into data1 and into the buffer; set tag=mem_addr and valid=1.
  - BUSY_D read: capture mem_rdata into the read register.
- **DONE**: for exactly one cycle, assert ready1 or ready2 for the port just served. New requests are not evaluated. Next state is IDLE.
- data2 is driven with the read register only during DONE following a port-2 read. Otherwise data2 is high-Z.
- Buffer coherence: a port-2 write whose address equals tag clears valid, at the same edge the write is issued.
- mem_ack while mem_req=0 is ignored.
- Datapath contract: a request is held stable until its ready pulse. It is deasserted or changed at the edge that ends the ready cycle.

## Timing
- Reset (async, reset_n=0): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data1=0, ready1=0, ready2=0, buffer valid=0, data2 high-Z.
- Reset asserted mid-transaction aborts it immediately. mem_req falls without waiting for clk.
- Memory access, request seen at edge E0:
  - mem_req high after E0.
  - Ack sampled at edge Ek (k≥1).
  - ready high in the cycle after Ek.
  - IDLE after Ek+1.
  - Minimum 2 cycles from the request edge to the ready pulse, with a 3-cycle request-to-request period.
- Buffer hit: ready1 is high in the cycle after E0; 2-cycle throughput.
- Simultaneous readM1 and port-2 request: port 2 is served first. Port 1 is served in the IDLE following that DONE, unless port 2 requests again.
- All outputs except data2 are registered. data2 enable is decoded from registered state.

## Test plan
- **Reset mid-transaction**: reset_n low during BUSY_D with mem_req=1 -> mem_req=0 immediately. After release: IDLE, ready1=ready2=0, and a fetch of 0x0000 misses.
- **Fetch miss then hit**: readM1, address1=0x0010, mem acks 1 cycle later with 0x6A05 -> data1=0x6A05 and a ready1 pulse 2 cycles after the request. Repeat the fetch -> ready1 the next cycle with mem_req never asserted.
- **Priority**: readM1 (0x0020) and readM2 (0x0100) high together, mem_rdata=0x1234 for data -> port 2 served first. data2=0x1234 only during the ready2 cycle. Then the fetch issues with mem_addr=0x0020.
- **Coherence**: buffered tag=0x0010, then writeM2 to 0x0010 with data2=0xBEEF -> mem_we=1 and mem_wdata=0xBEEF. The next fetch of 0x0010 goes to memory.
- **Stretched ack**: ack delayed 5 cycles -> mem_req, mem_addr and mem_we stay stable for all 5 cycles; exactly one ready pulse follows. A stray mem_ack in IDLE produces no ready.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port to single-port memory arbiter with one-entry fetch buffer
//
// Serializes the datapath's instruction-fetch port (port 1) and data port (port 2)
// onto one req/ack memory. Port 2 has fixed priority. A one-entry fetch buffer
// lets a repeated fetch of the same address finish without a memory access.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   readM1, address1             fetch request and address
//   data1, ready1                fetched word (registered), one-cycle completion pulse
//   readM2, writeM2, address2    data read/write request and address
//   data2                        write data in / read data out (driven only in DONE after a read)
//   ready2                       one-cycle port-2 completion pulse
//   mem_req, mem_we              memory request (held until ack), write enable
//   mem_addr, mem_wdata          memory address, write data
//   mem_rdata, mem_ack           memory read data, completion (valid while mem_req=1)

module mem_port_arbiter #(
  parameter int WIDTH  = 16,
  parameter bit HIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             readM1,
  input  logic [WIDTH-1:0] address1,
  output logic [WIDTH-1:0] data1,
  output logic             ready1,
  input  logic             readM2,
  input  logic             writeM2,
  input  logic [WIDTH-1:0] address2,
  inout  wire  [WIDTH-1:0] data2,
  output logic             ready2,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [WIDTH-1:0] data1_q;
  logic             ready1_q;
  logic             ready2_q;
  logic [WIDTH-1:0] rdata2_q;   // port-2 read register
  logic [WIDTH-1:0] buf_q;      // fetch buffer data
  logic [WIDTH-1:0] tag_q;      // fetch buffer address
  logic             valid_q;    // fetch buffer valid
  logic             port2_q;    // port currently being served: 1 = port 2

  logic             buf_hit;
  logic             ack_seen;
  logic             drive_d2;

  assign buf_hit  = HIT_EN && valid_q && (address1 == tag_q);
  // A stray ack while no request is outstanding must not complete anything.
  assign ack_seen = mem_req_q && mem_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data1_q     <= '0;
      ready1_q    <= 1'b0;
      ready2_q    <= 1'b0;
      rdata2_q    <= '0;
      buf_q       <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      port2_q     <= 1'b0;
    end else begin
      // Ready outputs are single-cycle pulses; only the transition into DONE raises one.
      ready1_q <= 1'b0;
      ready2_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (readM2 || writeM2) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= writeM2;
            mem_addr_q  <= address2;
            mem_wdata_q <= data2;
            port2_q     <= 1'b1;
            state_q     <= BUSY_D;
            // Keep the fetch buffer coherent with memory: drop it on a write to its address.
            if (writeM2 && (address2 == tag_q)) begin
              valid_q <= 1'b0;
            end
          end else if (readM1 && buf_hit) begin
            data1_q  <= buf_q;
            ready1_q <= 1'b1;
            port2_q  <= 1'b0;
            state_q  <= DONE;
          end else if (readM1) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= address1;
            port2_q    <= 1'b0;
            state_q    <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (ack_seen) begin
            mem_req_q <= 1'b0;
            data1_q   <= mem_rdata;
            buf_q     <= mem_rdata;
            tag_q     <= mem_addr_q;
            valid_q   <= 1'b1;
            ready1_q  <= 1'b1;
            state_q   <= DONE;
          end
        end
        BUSY_D: begin
          if (ack_seen) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              rdata2_q <= mem_rdata;
            end
            ready2_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // mem_we stays at the served access's value through DONE, so it identifies a port-2 read here.
  assign drive_d2 = (state_q == DONE) && port2_q && !mem_we_q;
  assign data2    = drive_d2 ? rdata2_q : {WIDTH{1'bz}};

  assign data1     = data1_q;
  assign ready1    = ready1_q;
  assign ready2    = ready2_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         readM1 = 1'b0;
  logic [W-1:0] address1 = '0;
  logic [W-1:0] data1;
  logic         ready1;
  logic         readM2 = 1'b0;
  logic         writeM2 = 1'b0;
  logic [W-1:0] address2 = '0;
  wire  [W-1:0] data2;
  logic         ready2;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  logic [W-1:0] d2_drv = '0;
  logic         d2_en = 1'b0;
  assign data2 = d2_en ? d2_drv : {W{1'bz}};

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .HIT_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .readM1(readM1), .address1(address1), .data1(data1), .ready1(ready1),
    .readM2(readM2), .writeM2(writeM2), .address2(address2), .data2(data2), .ready2(ready2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: memory contents plus the one-entry fetch buffer.
  logic [W-1:0] mem_m [logic [W-1:0]];
  logic         mv = 1'b0;
  logic [W-1:0] mtag = '0;
  logic [W-1:0] mdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] mem_read(input logic [W-1:0] a);
    if (!mem_m.exists(a)) mem_m[a] = W'($urandom);
    return mem_m[a];
  endfunction

  // One complete transaction starting at a negedge with the DUT idle.
  // kind: 0 = fetch, 1 = port-2 read, 2 = port-2 write; k = ack edge index (>=1).
  task automatic txn(input int kind, input logic [W-1:0] a, input logic [W-1:0] wd, input int k);
    logic         hit;
    logic [W-1:0] exp;
    hit = (kind == 0) && mv && (mtag == a);
    case (kind)
      0: begin readM1 = 1'b1; address1 = a; end
      1: begin readM2 = 1'b1; address2 = a; end
      default: begin
        writeM2 = 1'b1; address2 = a; d2_drv = wd; d2_en = 1'b1;
        if (mv && mtag == a) mv = 1'b0;
        mem_m[a] = wd;
      end
    endcase
    @(negedge clk);
    if (hit) begin
      chk("hit_ready1", ready1, 1);
      chk("hit_data1", data1, mdata);
      chk("hit_no_req", mem_req, 0);
    end else begin
      chk("req_rise", mem_req, 1);
      chk("req_addr", mem_addr, a);
      chk("req_we", mem_we, kind == 2);
      if (kind == 2) chk("req_wdata", mem_wdata, wd);
      exp = (kind == 2) ? wd : mem_read(a);
      for (int i = 1; i < k; i++) begin
        @(negedge clk);
        chk("hold_req", mem_req, 1);
        chk("hold_addr", mem_addr, a);
        chk("hold_we", mem_we, kind == 2);
        chk("hold_no_ready", {ready1, ready2}, 0);
      end
      mem_ack = 1'b1;
      mem_rdata = (kind == 2) ? W'($urandom) : exp;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = W'($urandom);
      chk("req_drop", mem_req, 0);
      if (kind == 0) begin
        chk("miss_ready", {ready1, ready2}, 2'b10);
        chk("miss_data1", data1, exp);
        mv = 1'b1; mtag = a; mdata = exp;
      end else begin
        chk("p2_ready", {ready1, ready2}, 2'b01);
        if (kind == 1) chk("p2_data2", data2, exp);
      end
    end
    readM1 = 1'b0; readM2 = 1'b0; writeM2 = 1'b0; d2_en = 1'b0;
    @(negedge clk);
    chk("ready_clear", {ready1, ready2}, 0);
    chk("idle_req", mem_req, 0);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_data1", data1, 0);
    chk("rst_ready", {ready1, ready2}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fetch miss then hit
    mem_m[16'h0010] = 16'h6A05;
    txn(0, 16'h0010, '0, 1);
    txn(0, 16'h0010, '0, 1);

    // Priority: port 2 before port 1
    mem_m[16'h0100] = 16'h1234;
    mem_m[16'h0020] = 16'h5A5A;
    readM1 = 1'b1; address1 = 16'h0020;
    readM2 = 1'b1; address2 = 16'h0100;
    @(negedge clk);
    chk("pri_addr2", mem_addr, 16'h0100);
    chk("pri_we", mem_we, 0);
    chk("pri_d2_busy", data2 !== 16'h1234, 1);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("pri_ready", {ready1, ready2}, 2'b01);
    chk("pri_data2", data2, 16'h1234);
    readM2 = 1'b0;
    @(negedge clk);
    chk("pri_d2_after", data2 !== 16'h1234, 1);
    chk("pri_gap_req", mem_req, 0);
    @(negedge clk);
    chk("pri_f_req", mem_req, 1);
    chk("pri_f_addr", mem_addr, 16'h0020);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("pri_f_ready", {ready1, ready2}, 2'b10);
    chk("pri_f_data1", data1, 16'h5A5A);
    readM1 = 1'b0;
    mv = 1'b1; mtag = 16'h0020; mdata = 16'h5A5A;
    @(negedge clk);

    // Coherence: refill tag 0x0010, write it, next fetch must miss
    txn(0, 16'h0010, '0, 1);
    txn(2, 16'h0010, 16'hBEEF, 2);
    txn(0, 16'h0010, '0, 1);

    // Stretched ack
    txn(1, 16'h0040, '0, 5);
    txn(0, 16'h0050, '0, 5);

    // Stray ack while idle
    mem_ack = 1'b1;
    @(negedge clk);
    chk("stray_ready", {ready1, ready2}, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ready2", {ready1, ready2}, 0);
    chk("stray_req", mem_req, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      txn(int'($urandom_range(0, 2)), W'(16 * $urandom_range(0, 3)), W'($urandom),
          int'($urandom_range(1, 4)));
    end

    // Reset mid-transaction
    readM2 = 1'b1; address2 = 16'h0030;
    @(negedge clk);
    chk("mid_req", mem_req, 1);
    #2 reset_n = 1'b0;
    #1 chk("mid_async_drop", mem_req, 0);
    readM2 = 1'b0;
    mv = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", {ready1, ready2}, 0);
    chk("mid_req_idle", mem_req, 0);
    txn(0, 16'h0000, '0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
